// File: rtl/qam_pkg.sv
// qam_pkg: shared types and constants for the QAM symbol scheduler
package qam_pkg;
  localparam int SYM_LEN_DEFAULT = 128;
  typedef logic [1:0] qam_sym_t;
  localparam qam_sym_t IDLE_SYM = 2'b00;
  typedef enum logic [1:0] {INIT, IDLE, RUN} sched_state_t;
endpackage

// File: rtl/qam_symbol_scheduler_if.sv
// qam_symbol_scheduler_if: bit-stream input and modulator-side outputs of the scheduler
interface qam_symbol_scheduler_if #(parameter int FIFO_DEPTH = 4);
  import qam_pkg::*;
  logic bit_in, bit_valid, bit_ready, flush, init_tab, sym_strobe, underflow, busy;
  qam_sym_t conv_out;
  logic [$clog2(FIFO_DEPTH):0] level;
  modport master (output bit_in, bit_valid, flush,
                  input bit_ready, conv_out, init_tab, sym_strobe, underflow, level, busy);
  modport slave (input bit_in, bit_valid, flush,
                 output bit_ready, conv_out, init_tab, sym_strobe, underflow, level, busy);
endinterface

// File: rtl/qam_sym_fifo.sv
// qam_sym_fifo: symbol FIFO with extra-MSB pointer wrap; callers never push when full without a pop
module qam_sym_fifo import qam_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  logic     flush,
  input  qam_sym_t din,
  output qam_sym_t dout,
  output logic     full,
  output logic     empty,
  output logic [AW:0] level
);
  logic [AW:0] wr, rd;
  qam_sym_t mem [DEPTH];
  assign level = wr - rd;
  assign empty = wr == rd;
  assign full = level == (AW+1)'(DEPTH);
  assign dout = mem[rd[AW-1:0]];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr <= '0;
      rd <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
    end else begin
      wr <= wr + (AW+1)'(push);
      rd <= rd + (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr[AW-1:0]] <= din;
endmodule

// File: rtl/qam_symbol_scheduler.sv
// qam_symbol_scheduler: packs bit pairs into symbols and releases one per modulator symbol boundary
module qam_symbol_scheduler import qam_pkg::*; #(
  parameter int SYM_LEN = SYM_LEN_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter qam_sym_t IDLE_SYM = qam_pkg::IDLE_SYM
) (
  input logic clk,
  input logic reset,
  qam_symbol_scheduler_if.slave bus
);
  localparam int PW = $clog2(SYM_LEN);
  logic [PW-1:0] phase;
  sched_state_t state, state_n;
  logic half_v, half_b, boundary, full, empty, pop, push, xfer, init_q, uf_q;
  qam_sym_t head, conv_q;
  qam_sym_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .flush(bus.flush),
    .din({half_b, bus.bit_in}), .dout(head), .full(full), .empty(empty), .level(bus.level)
  );
  assign boundary = phase == PW'(SYM_LEN - 1);
  assign pop = boundary && !empty && !bus.flush && state != INIT;
  assign bus.bit_ready = !bus.flush && (!full || pop);
  assign xfer = bus.bit_valid && bus.bit_ready;
  assign push = xfer && half_v;
  assign bus.sym_strobe = phase == '0;
  assign bus.busy = state == RUN;
  assign bus.conv_out = conv_q;
  assign bus.init_tab = init_q;
  assign bus.underflow = uf_q;
  always_comb begin
    state_n = state;
    state_n = state == INIT ? IDLE : bus.flush ? IDLE : pop ? RUN : state;
  end
  // phase is never held, so it tracks the modulator's own counter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      phase <= '0;
      state <= INIT;
      half_v <= 1'b0;
      half_b <= 1'b0;
      conv_q <= IDLE_SYM;
      init_q <= 1'b0;
      uf_q <= 1'b0;
    end else begin
      phase <= phase + PW'(1);
      state <= state_n;
      init_q <= state == INIT;
      uf_q <= boundary && state == RUN && empty && !bus.flush;
      if (boundary) conv_q <= pop ? head : IDLE_SYM;
      if (bus.flush) half_v <= 1'b0;
      else if (xfer) begin
        half_v <= !half_v;
        half_b <= bus.bit_in;
      end
    end
endmodule

// File: tb/tb_qam_symbol_scheduler.sv
// tb_qam_symbol_scheduler: cycle model with a symbol scoreboard queue checked at every boundary
module tb_qam_symbol_scheduler;
  import qam_pkg::*;
  localparam int SYM_LEN = 128;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  qam_symbol_scheduler_if #(.FIFO_DEPTH(DEPTH)) bus();
  qam_symbol_scheduler #(.SYM_LEN(SYM_LEN), .FIFO_DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_checks = 0;
  int n_fail = 0;
  qam_sym_t m_fifo[$];
  qam_sym_t m_conv;
  int m_phase;
  bit m_init, m_half, m_hb, m_busy, m_uf, m_init_q;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  task automatic model_reset();
    m_fifo.delete();
    m_phase = 0;
    m_init = 1;
    m_half = 0;
    m_hb = 0;
    m_busy = 0;
    m_uf = 0;
    m_init_q = 0;
    m_conv = IDLE_SYM;
  endtask
  task automatic check_reset_values();
    check("rst_conv_out", bus.conv_out, 2'b00);
    check("rst_init_tab", bus.init_tab, 1'b0);
    check("rst_sym_strobe", bus.sym_strobe, 1'b1);
    check("rst_underflow", bus.underflow, 1'b0);
    check("rst_level", bus.level, 0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_bit_ready", bus.bit_ready, 1'b1);
  endtask
  task automatic step(output bit xfer);
    bit bnd, pop, rdy;
    #1;
    bnd = m_phase == SYM_LEN - 1;
    pop = bnd && !m_init && m_fifo.size() > 0 && !bus.flush;
    rdy = !bus.flush && (m_fifo.size() < DEPTH || pop);
    check("bit_ready", bus.bit_ready, rdy);
    xfer = bus.bit_valid && rdy;
    @(posedge clk);
    m_uf = 0;
    if (bnd) begin
      if (pop) begin
        m_conv = m_fifo.pop_front();
        m_busy = 1;
      end else begin
        m_conv = IDLE_SYM;
        m_uf = m_busy && !bus.flush;
      end
    end
    if (bus.flush) begin
      m_fifo.delete();
      m_half = 0;
      if (!m_init) m_busy = 0;
    end else if (xfer) begin
      if (m_half) m_fifo.push_back({m_hb, bus.bit_in});
      else m_hb = bus.bit_in;
      m_half = !m_half;
    end
    m_init_q = m_init;
    m_init = 0;
    m_phase = (m_phase + 1) % SYM_LEN;
    #1;
    check("conv_out", bus.conv_out, m_conv);
    check("underflow", bus.underflow, m_uf);
    check("level", bus.level, m_fifo.size());
    check("busy", bus.busy, m_busy);
    check("init_tab", bus.init_tab, m_init_q);
    check("sym_strobe", bus.sym_strobe, m_phase == 0);
  endtask
  task automatic idle(input int n);
    bit x;
    bus.bit_valid = 0;
    repeat (n) step(x);
  endtask
  task automatic wait_phase(input int p);
    bit x;
    bus.bit_valid = 0;
    while (m_phase != p) step(x);
  endtask
  task automatic send(input logic [15:0] bits, input int n);
    int i = 0;
    int budget = 0;
    bit x;
    while (i < n && budget < 1000) begin
      bus.bit_valid = 1;
      bus.bit_in = bits[i];
      step(x);
      if (x) i++;
      budget++;
    end
    bus.bit_valid = 0;
    check("send_done", i, n);
  endtask
  initial begin
    bus.bit_in = 0;
    bus.bit_valid = 0;
    bus.flush = 0;
    model_reset();
    #12;
    check_reset_values();
    reset = 1;
    idle(260);
    wait_phase(5);
    send(16'b01, 2);
    idle(300);
    wait_phase(3);
    send(16'b1000011110, 10);
    idle(800);
    wait_phase(10);
    send(16'b1011010, 7);
    wait_phase(50);
    check("pre_flush_level", bus.level, 3);
    bus.flush = 1;
    idle(1);
    bus.flush = 0;
    check("post_flush_level", bus.level, 0);
    check("post_flush_busy", bus.busy, 1'b0);
    idle(200);
    send(16'b11, 2);
    wait_phase(1);
    check("pre_reset_busy", bus.busy, 1'b1);
    wait_phase(70);
    reset = 0;
    #1;
    check_reset_values();
    model_reset();
    #2;
    reset = 1;
    idle(300);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/qam_symbol_scheduler.md
# qam_symbol_scheduler

Sequencer that feeds the QAM modulator. It accepts a serial bit stream over a valid/ready handshake and packs bit pairs into 2-bit symbols. It buffers the symbols and presents one on `conv_out` exactly at each 128-sample symbol boundary of the modulator. It also generates the modulator's table-init pulse and inserts idle symbols on underflow. It shares clock and reset with the modulator and sits directly in front of it.

## Interface
- `SYM_LEN`, 128: samples per symbol; must equal the modulator's count period (power of two).
- `FIFO_DEPTH`, 4: symbol FIFO entries (power of two, ≥2).
- `IDLE_SYM`, 2'b00: symbol emitted when no data is available.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `bit_in`  in  1  serial data bit.
- `bit_valid`  in  1  `bit_in` valid.
- `bit_ready`  out  1  block accepts a bit this cycle.
- `flush`  in  1  synchronous clear of buffered data.
- `conv_out`  out  2  symbol to modulator `conv_in`.
- `init_tab`  out  1  table-init pulse to modulator.
- `sym_strobe`  out  1  high in the cycle the modulator latches `conv_out` (phase 0).
- `underflow`  out  1  one-cycle pulse: boundary reached in RUN with empty FIFO.
- `level`  out  $clog2(FIFO_DEPTH)+1  symbols buffered.
- `busy`  out  1  state == RUN.

## Operation
- Reset values:
  - `phase`=0, `conv_out`=IDLE_SYM, `init_tab`=0, `sym_strobe`=1, `underflow`=0, `level`=0, `busy`=0.
  - Half-pair register is empty.
  - State = INIT.
- States:
  - INIT: `init_tab`=1 for exactly one cycle, then IDLE unconditionally.
  - IDLE: at a boundary, if the FIFO is non-empty, pop and go to RUN. Otherwise emit IDLE_SYM with no underflow.
  - RUN: at a boundary, if the FIFO is non-empty, pop. If it is empty, emit IDLE_SYM, pulse `underflow`, and stay in RUN.
  - `flush` in any state except INIT returns to IDLE.
- Phase counter: free-running modulo SYM_LEN from reset and never stalled, including by flush, so it stays aligned with the modulator's counter.
- Boundary: the cycle with `phase`==SYM_LEN-1. `conv_out` is registered at the boundary, so it is valid while `phase`==0.
- `conv_out` holds its value for the other SYM_LEN-1 cycles.
- Packing:
  - A bit transfers when `bit_valid & bit_ready`.
  - The first bit of a pair goes to `conv_out[1]` and the second to `conv_out[0]`.
  - The completed pair is pushed in the same cycle the second bit transfers.
- `bit_ready` = !full, or a pop occurs this cycle. When the half-pair register is empty, a first bit is always accepted only if the FIFO is not full.
- Simultaneous push and pop at full: both occur and `level` is unchanged. At empty, a push in a boundary cycle is not visible to that pop.
- `flush`:
  - Empties the FIFO and the half-pair register.
  - Has priority over a push in the same cycle.
  - Deasserts `bit_ready` for that cycle.
  - `conv_out` keeps its current value until the next boundary.

## Timing
- Reset deassertion, then the first rising edge: `init_tab`=1. The second edge: `init_tab`=0, which stays 0 until the next reset.
- `sym_strobe` is high when `phase`==0, i.e. cycles 0, SYM_LEN, 2·SYM_LEN… after reset.
- Latency: the second bit of a pair accepted at cycle t with an empty FIFO appears on `conv_out` at the first boundary ≥ t+1. The symbol is observed at the next phase 0.
- `underflow` is coincident with `sym_strobe` (registered at the boundary).
- `level` updates on the edge after push/pop.
- Async reset mid-symbol: all state is cleared immediately. The modulator resets together with this block, so alignment is preserved.

## Structure
- Package `qam_pkg`:
  - `SYM_LEN_DEFAULT`
  - typedef `qam_sym_t` (logic [1:0])
  - `IDLE_SYM` constant
  - state enum `sched_state_t` {INIT, IDLE, RUN}
- Sub-module `qam_sym_fifo`: synchronous FIFO of `qam_sym_t` with push, pop, flush, full, empty and level, using pointer wrap via an extra MSB.
- Top level holds the phase counter, FSM, packer and output registers.

## Test plan
- Reset release, no input → `init_tab` high cycle 1 only; `conv_out`=00 forever; `underflow` never; `busy`=0.
- Push bits 1,0 at cycle 5 → `conv_out`=10 at cycle 128 (phase 0), `busy`=1. At the next boundary with no data, `underflow` pulses at cycle 256 and `conv_out`=00.
- Stream 10 bits (pairs 01,11,10,00,01) with FIFO_DEPTH=4 → `bit_ready` drops when `level`=4. Symbols appear in order, one per 128 cycles, and the backpressured pair is accepted after the first pop.
- Hold `bit_valid` continuously at full across a boundary → push and pop in the same cycle; `level` stays 4 with no lost symbol.
- `flush` with `level`=3 and a half pair pending at phase 50 → `level`=0 the next cycle, and `busy`=0. The next boundary emits 00 with no `underflow`.
- Assert `reset` at phase 70 mid-RUN → outputs return to reset values immediately. After release, `sym_strobe` is high in cycle 0 and `init_tab` pulses again.
